mem_port_arbiter: RTL and testbench

- N-master to single-memory-port arbiter for the 128-bit req/gnt/rvalid memory interface used by the core, the UART programmer and future DMA masters.
- Replaces the fixed two-way programmer/core mux with three features:
  - parametrised channel count;
  - round-robin fairness with a lock override for exclusive programming access;
  - in-order read-response routing through an outstanding-ID FIFO, so masters never see each other's rdata/rvalid.

---
 rtl/mem_arb_pkg.sv | 42 ++++
 rtl/mem_arb_id_fifo.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths, request bundle and round-robin helper
// for the memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 128;
  localparam int STRB_W    = DATA_W / 8;
  localparam int MAX_PORTS = 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_sel_t;

  // First set bit scanning ptr, ptr+1, ... modulo n.
  function automatic rr_sel_t rr_select(
    input logic [MAX_PORTS-1:0] req_vec,
    input logic [2:0]           ptr,
    input logic [3:0]           n
  );
    rr_sel_t    r;
    logic [3:0] k;
    r = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      k = {1'b0, ptr} + 4'(i);
      if (k >= n) k = k - n;
      if (!r.valid && (4'(i) < n) && req_vec[k[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = k[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// FIFO of port indices for accepted reads; pointers carry
// a wrap bit so full and empty are distinguishable.
module mem_arb_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head_id,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head_id = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-master round-robin arbiter onto one memory port with
// lock override and in-order read response routing.
module mem_port_arbiter #(
  parameter int NUM_PORTS       = 3,
  parameter int ADDR_W          = mem_arb_pkg::ADDR_W,
  parameter int DATA_W          = mem_arb_pkg::DATA_W,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W          = $clog2(NUM_PORTS),
  localparam int STRB_W         = DATA_W / 8,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        lock_en_i,
  input  logic [IDX_W-1:0]            lock_id_i,
  input  logic [NUM_PORTS-1:0]        m_req_i,
  input  logic [NUM_PORTS-1:0]        m_we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] m_wdata_i,
  input  logic [NUM_PORTS*STRB_W-1:0] m_wstrb_i,
  output logic [NUM_PORTS-1:0]        m_gnt_o,
  output logic [NUM_PORTS*DATA_W-1:0] m_rdata_o,
  output logic [NUM_PORTS-1:0]        m_rvalid_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic [STRB_W-1:0]           mem_wstrb_o,
  input  logic                        mem_gnt_i,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  input  logic                        mem_rvalid_i,
  output logic                        resp_err_o,
  output logic [CNT_W-1:0]            outstanding_o
);

  import mem_arb_pkg::*;

  logic [NUM_PORTS-1:0] elig;
  logic [MAX_PORTS-1:0] elig_pad;
  rr_sel_t              pick;
  logic                 sel_valid;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     rr_next;
  logic [3:0]           sel_inc;
  logic                 hs;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [IDX_W-1:0]     head_id;

  // Lock masking leaves only lock_id_i eligible, so the
  // round-robin scan then picks it whenever it can go.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      elig[k] = m_req_i[k]
              & (~lock_en_i | (lock_id_i == IDX_W'(k)))
              & (m_we_i[k] | ~fifo_full);
    end
  end

  always_comb begin
    elig_pad = '0;
    elig_pad[NUM_PORTS-1:0] = elig;
  end

  assign pick      = rr_select(elig_pad, 3'(rr_ptr), 4'(NUM_PORTS));
  assign sel_valid = pick.valid & ~rst_i;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    m_gnt_o     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel_valid && (pick.idx == 3'(k))) begin
        mem_req_o   = 1'b1;
        mem_we_o    = m_we_i[k];
        mem_addr_o  = m_addr_i[k*ADDR_W +: ADDR_W];
        mem_wdata_o = m_wdata_i[k*DATA_W +: DATA_W];
        mem_wstrb_o = m_wstrb_i[k*STRB_W +: STRB_W];
        m_gnt_o[k]  = mem_gnt_i;
      end
    end
  end

  assign hs      = mem_req_o & mem_gnt_i;
  assign push    = hs & ~mem_we_o;
  assign pop     = mem_rvalid_i & ~fifo_empty;
  assign sel_inc = {1'b0, pick.idx} + 4'd1;
  assign rr_next = (sel_inc == 4'(NUM_PORTS)) ? '0
                                              : sel_inc[IDX_W-1:0];

  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (pop && (head_id == IDX_W'(k))) begin
        m_rvalid_o[k]                = 1'b1;
        m_rdata_o[k*DATA_W +: DATA_W] = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      resp_err_o <= 1'b0;
    end else begin
      if (hs) rr_ptr <= rr_next;
      if (mem_rvalid_i && fifo_empty) resp_err_o <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (push),
    .push_id (pick.idx[IDX_W-1:0]),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding_o)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: read owners are
// queued on grant and popped when responses come back.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = 16;
  localparam int MO = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            lock_en_i;
  logic [1:0]      lock_id_i;
  logic [NP-1:0]   m_req_i;
  logic [NP-1:0]   m_we_i;
  logic [NP*AW-1:0] m_addr_i;
  logic [NP*DW-1:0] m_wdata_i;
  logic [NP*SW-1:0] m_wstrb_i;
  logic [NP-1:0]   m_gnt_o;
  logic [NP*DW-1:0] m_rdata_o;
  logic [NP-1:0]   m_rvalid_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [SW-1:0]   mem_wstrb_o;
  logic            mem_gnt_i;
  logic [DW-1:0]   mem_rdata_i;
  logic            mem_rvalid_i;
  logic            resp_err_o;
  logic [2:0]      outstanding_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .NUM_PORTS       (NP),
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lock_en_i     (lock_en_i),
    .lock_id_i     (lock_id_i),
    .m_req_i       (m_req_i),
    .m_we_i        (m_we_i),
    .m_addr_i      (m_addr_i),
    .m_wdata_i     (m_wdata_i),
    .m_wstrb_i     (m_wstrb_i),
    .m_gnt_o       (m_gnt_o),
    .m_rdata_o     (m_rdata_o),
    .m_rvalid_o    (m_rvalid_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_wstrb_o   (mem_wstrb_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rdata_i   (mem_rdata_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .resp_err_o    (resp_err_o),
    .outstanding_o (outstanding_o)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_q[$];
  int   rr_m    = 0;
  logic err_m   = 1'b0;
  logic [2:0] g;

  function automatic logic [AW-1:0] addr_of(input int k);
    return 32'h1000_0000 + 32'(k) * 32'h40;
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int k);
    return {4{32'hD000_0000 | 32'(k)}};
  endfunction

  function automatic logic [SW-1:0] wstrb_of(input int k);
    return 16'h00FF << k;
  endfunction

  task automatic chk(input string tag,
                     input logic [383:0] got,
                     input logic [383:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_sel(input logic [2:0] req,
                                   input logic [2:0] we);
    int k;
    for (int i = 0; i < NP; i++) begin
      k = (rr_m + i) % NP;
      if (req[k] && (!lock_en_i || k == int'(lock_id_i)) &&
          (we[k] || exp_q.size() < MO))
        return k;
    end
    return -1;
  endfunction

  // Entered just after a rising edge; leaves just after the next.
  task automatic cyc(input logic [2:0] req, input logic [2:0] we,
                     input logic gnt, input logic rv,
                     input logic [DW-1:0] rd,
                     output logic [2:0] gs);
    int s;
    int own;
    mem_req_t er;
    logic [383:0] erd;
    logic [2:0] ev;
    m_req_i      = req;
    m_we_i       = we;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    #3;
    s  = model_sel(req, we);
    er = '0;
    if (s >= 0) begin
      er.we    = we[s];
      er.addr  = addr_of(s);
      er.wdata = wdata_of(s);
      er.wstrb = wstrb_of(s);
    end
    chk("mem_req", mem_req_o, s >= 0);
    chk("mem_bus", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o}, er);
    chk("gnt", m_gnt_o, (s >= 0) ? ({2'b0, gnt} << s) : 3'b0);
    erd = '0;
    ev  = '0;
    own = -1;
    if (rv && exp_q.size() > 0) begin
      own = exp_q[0];
      ev[own] = 1'b1;
      erd[own*DW +: DW] = rd;
    end
    chk("rvalid", m_rvalid_o, ev);
    chk("rdata", m_rdata_o, erd);
    gs = m_gnt_o;
    @(posedge clk_i);
    if (rv) begin
      if (own >= 0) void'(exp_q.pop_front());
      else err_m = 1'b1;
    end
    if (s >= 0 && gnt) begin
      rr_m = (s + 1) % NP;
      if (!we[s]) exp_q.push_back(s);
    end
    #1;
    chk("outstanding", outstanding_o, exp_q.size());
    chk("resp_err", resp_err_o, err_m);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++)
      cyc(3'b000, 3'b000, 1'b0, 1'b1, 128'hC0 + 128'(i), g);
  endtask

  initial begin
    rst_i        = 1'b1;
    lock_en_i    = 1'b0;
    lock_id_i    = '0;
    m_req_i      = 3'b111;
    m_we_i       = '0;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    for (int k = 0; k < NP; k++) begin
      m_addr_i[k*AW +: AW]  = addr_of(k);
      m_wdata_i[k*DW +: DW] = wdata_of(k);
      m_wstrb_i[k*SW +: SW] = wstrb_of(k);
    end
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_gnt", m_gnt_o, 3'b000);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", resp_err_o, 1'b0);
    rst_i = 1'b0;

    // round-robin reads, responses back to owners
    cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g); chk("rr0", g, 3'b001);
    cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g); chk("rr1", g, 3'b010);
    cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g); chk("rr2", g, 3'b100);
    cyc(3'b111, 3'b000, 1'b1, 1'b1, 128'hA0, g); chk("rr3", g, 3'b001);
    cyc(3'b111, 3'b000, 1'b1, 1'b1, 128'hA1, g); chk("rr4", g, 3'b010);
    cyc(3'b111, 3'b000, 1'b1, 1'b1, 128'hA2, g); chk("rr5", g, 3'b100);
    cyc(3'b000, 3'b000, 1'b0, 1'b1, 128'hA0, g);
    cyc(3'b000, 3'b000, 1'b0, 1'b1, 128'hA1, g);
    cyc(3'b000, 3'b000, 1'b0, 1'b1, 128'hA2, g);

    // port 1 stalled by mem_gnt_i
    for (int i = 0; i < 3; i++) begin
      cyc(3'b010, 3'b000, 1'b0, 1'b0, '0, g);
      chk("stall_gnt", g, 3'b000);
    end
    cyc(3'b010, 3'b000, 1'b1, 1'b0, '0, g); chk("stall_rel", g, 3'b010);
    cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g); chk("after_stall", g, 3'b100);
    drain();

    // lock on port 2
    lock_en_i = 1'b1;
    lock_id_i = 2'd2;
    cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g); chk("lock0", g, 3'b100);
    cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g); chk("lock1", g, 3'b100);
    cyc(3'b011, 3'b000, 1'b1, 1'b0, '0, g); chk("lock_idle", g, 3'b000);
    lock_en_i = 1'b0;
    cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g); chk("unlock", g, 3'b001);
    drain();

    // fill the ID FIFO, then writes still pass
    for (int i = 0; i < MO; i++) cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g);
    chk("full_cnt", outstanding_o, 3'd4);
    cyc(3'b100, 3'b000, 1'b1, 1'b0, '0, g); chk("full_hold", g, 3'b000);
    cyc(3'b101, 3'b001, 1'b1, 1'b0, '0, g); chk("full_write", g, 3'b001);
    chk("full_cnt2", outstanding_o, 3'd4);

    // response while full frees a slot; next read then pushes+pops
    cyc(3'b100, 3'b000, 1'b1, 1'b1, 128'hB0, g); chk("full_rv", g, 3'b000);
    cyc(3'b100, 3'b000, 1'b1, 1'b1, 128'hB1, g); chk("pushpop", g, 3'b100);
    chk("pushpop_cnt", outstanding_o, 3'd3);
    drain();

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      lock_en_i = ($urandom_range(0, 7) == 0);
      lock_id_i = 2'($urandom_range(0, 2));
      cyc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)),
          (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
          {$urandom, $urandom, $urandom, $urandom}, g);
    end
    lock_en_i = 1'b0;
    drain();

    // stray response
    cyc(3'b000, 3'b000, 1'b0, 1'b1, 128'hEE, g);
    chk("stray_rv", g, 3'b000);
    cyc(3'b000, 3'b000, 1'b0, 1'b0, '0, g);

    // reset in the middle of a burst
    cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g);
    cyc(3'b111, 3'b000, 1'b1, 1'b0, '0, g);
    m_req_i      = 3'b111;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    rst_i        = 1'b1;
    #2;
    chk("mid_rst_gnt", m_gnt_o, 3'b000);
    chk("mid_rst_req", mem_req_o, 1'b0);
    chk("mid_rst_rv", m_rvalid_o, 3'b000);
    chk("mid_rst_cnt", outstanding_o, 0);
    chk("mid_rst_err", resp_err_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    rr_m  = 0;
    err_m = 1'b0;
    cyc(3'b000, 3'b000, 1'b0, 1'b1, 128'hFF, g);
    cyc(3'b001, 3'b000, 1'b1, 1'b0, '0, g); chk("post_rst", g, 3'b001);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
